val2_shift_engine: RTL and testbench
====================================

Name: val2_shift_engine

Overview:
- Sequential, parametrised successor to the combinational operand-2 generator in the EXE stage.
- Produces ARM operand-2 (val2) plus shifter carry-out. Covers immediate rotate, immediate-amount shifts and register-amount (Rs) shifts, including the LSR/ASR #32, RRX and >=width special cases.
- Shifts iteratively, STEP bit positions per cycle, behind a valid/ready handshake with a synchronous flush for pipeline kill.

Parameters:
- DATA_W, 32, datapath width; power of two, >=16.
- STEP, 8, max bit positions shifted per cycle; power of two, 1..DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; priority over everything except rst.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept.
- rm  in  DATA_W  operand register value.
- rs_amt  in  8  Rs[7:0], register shift amount.
- shift_operand  in  12  instruction [11:0].
- immd  in  1  immediate form (I bit).
- reg_shift  in  1  amount from rs_amt (instruction bit 4).
- is_mem_command  in  1  LDR/STR offset form.
- carry_in  in  1  current C flag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- val2_out  out  DATA_W  result.
- carry_out  out  1  shifter carry.

Behaviour:
- Reset (async, rst=1): state IDLE; out_valid=0, val2_out=0, carry_out=0.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- States IDLE, SHIFT, DONE.
- Accept occurs when in_valid && in_ready && !flush. On accept the decoder yields preload value P, preload carry Cp, amount A, kind K and fill bit F.
  - Accept with A==0: go to DONE, with result P and carry Cp.
  - Accept with A>0: go to SHIFT, with work register P and remaining count A.
- SHIFT: each cycle shift by s=min(STEP, remaining). Carry = last bit shifted out. Remaining -= s. When remaining reaches 0, go to DONE.
- Latency: out_valid rises 1+ceil(A/STEP) cycles after the accept edge.
- DONE holds out_valid=1 with stable val2_out/carry_out until out_ready.
  - out_ready with no new accept: go to IDLE.
  - Simultaneous out_ready and accept: back-to-back load; no bubble.
- Decode rules (sh = shift_operand[11:7], typ = shift_operand[6:5], rot = shift_operand[11:8]):
  - is_mem_command: P = zero-extended shift_operand; A=0; Cp=carry_in. This has priority over immd.
  - immd: P = zero-extended shift_operand[7:0]; K=ROR; A = 2*rot mod DATA_W.
    - Carry = new MSB if A>0, else carry_in.
  - Immediate amount, sh!=0: P=rm; K=typ; A=sh.
  - Immediate amount, sh==0:
    - LSL: rm, carry_in.
    - LSR: A=DATA_W.
    - ASR: A=DATA_W.
    - ROR: RRX, i.e. A=1, K=ROR, F=carry_in; result {carry_in, rm[MSB:1]}, carry rm[0].
  - Register amount n=rs_amt, n==0: rm, carry_in, A=0.
  - Register amount, LSL/LSR:
    - n<=DATA_W: A=n.
    - n>DATA_W: P=0, Cp=0, A=0.
  - Register amount, ASR: A = min(n, DATA_W).
  - Register amount, ROR:
    - n mod DATA_W == 0 (n!=0): rm, carry rm[MSB], A=0.
    - Otherwise: A = n mod DATA_W.
- Fill bits:
  - LSL/LSR: 0.
  - ASR: original sign bit.
  - ROR: wrapped bits.
  - RRX: F.
- Carry when A==0 and not a special case: carry_in.
- flush in any state: next state IDLE, out_valid=0, in-flight op discarded. An accept in the same cycle as flush is ignored.
- rst asserted mid-SHIFT: immediate return to reset values.
- Inputs are sampled only at accept; later input changes have no effect.

Decomposition:
- Package val2_pkg holds:
  - shift_kind_t {LSL=2'b00, LSR=2'b01, ASR=2'b10, ROR=2'b11}.
  - state_t {IDLE, SHIFT, DONE}.
  - Preload struct {P, Cp, A, K, F}.
- Sub-module val2_decode (combinational): inputs to preload struct. val2_shift_engine holds the FSM, counter and step shifter.

Test Plan:
- Immediate rotate: immd=1, shift_operand=12'h4FF, STEP=8. Result val2_out=32'hFF000000, carry_out=1; out_valid 2 cycles after accept.
- LSR #32: rm=32'h80000001, shift_operand[11:7]=0, typ=LSR. Result val2_out=0, carry_out=1; latency 1+32/STEP=5 cycles.
- RRX: rm=32'h00000003, carry_in=1, typ=ROR, sh=0. Result val2_out=32'h80000001, carry_out=1.
- Register LSL, rs_amt=33, rm=32'hFFFFFFFF: result 0, carry 0, latency 1. Register ROR, rs_amt=32, rm=32'h80000000: result rm, carry 1.
- Handshake: out_ready=0 for 3 cycles in DONE means outputs stable and in_ready=0. Raising out_ready together with a pending in_valid gives a back-to-back accept.
- Flush and reset: flush during SHIFT returns to IDLE next cycle with no out_valid. rst asserted mid-SHIFT forces out_valid=0, val2_out=0 asynchronously.

Source files
------------

// File: rtl/val2_pkg.sv
// -----------------------------------------------------------------------------
// val2_pkg
// Shared types for the operand-2 shift engine.
//   shift_kind_t : ARM shift type encoding (instruction bits [6:5]).
//   state_t      : engine FSM states.
//   preload_t    : decoder output, the first value loaded into the engine:
//                  P (value), Cp (carry if no shifting happens), A (amount),
//                  K (kind), F (fill bit), rrx (one-bit rotate through carry).
// P is sized for the widest supported datapath (VAL2_MAX_W). Engines narrower
// than that use the low DATA_W bits only. A is 8 bits, which limits
// DATA_W to 128 or less.
// -----------------------------------------------------------------------------
package val2_pkg;

  localparam int VAL2_MAX_W = 128;
  localparam int VAL2_AMT_W = 8;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_kind_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [VAL2_MAX_W-1:0] P;
    logic                  Cp;
    logic [VAL2_AMT_W-1:0] A;
    shift_kind_t           K;
    logic                  F;
    logic                  rrx;
  } preload_t;

endpackage

// File: rtl/val2_decode.sv
// -----------------------------------------------------------------------------
// val2_decode
// Combinational decoder. It turns the instruction operand-2 fields into the
// preload record for the iterative shifter. It also resolves every special
// case up front: LSR/ASR #32, RRX, register amounts of DATA_W or more, and
// register ROR by a multiple of DATA_W. The engine then only performs plain
// shifts of A bit positions.
// Ports:
//   rm             in  DATA_W  operand register value
//   rs_amt         in  8       register shift amount (Rs[7:0])
//   shift_operand  in  12      instruction [11:0]
//   immd           in  1       immediate form
//   reg_shift      in  1       shift amount comes from rs_amt
//   is_mem_command in  1       LDR/STR offset form (wins over immd)
//   carry_in       in  1       current C flag
//   pre            out preload_t
// -----------------------------------------------------------------------------
module val2_decode
  import val2_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rm,
  input  logic [7:0]        rs_amt,
  input  logic [11:0]       shift_operand,
  input  logic              immd,
  input  logic              reg_shift,
  input  logic              is_mem_command,
  input  logic              carry_in,
  output preload_t          pre
);

  localparam logic [VAL2_AMT_W-1:0] W_AMT  = VAL2_AMT_W'(DATA_W);
  localparam logic [VAL2_AMT_W-1:0] W_MASK = VAL2_AMT_W'(DATA_W - 1);

  logic [4:0]            w_sh;
  logic [3:0]            w_rot;
  shift_kind_t           w_kind;
  logic [VAL2_AMT_W-1:0] w_rot_amt;
  logic [VAL2_AMT_W-1:0] w_rs_mod;

  assign w_sh   = shift_operand[11:7];
  assign w_rot  = shift_operand[11:8];
  assign w_kind = shift_kind_t'(shift_operand[6:5]);

  // DATA_W is a power of two, so "mod DATA_W" is a mask.
  assign w_rot_amt = {3'b000, w_rot, 1'b0} & W_MASK;
  assign w_rs_mod  = rs_amt & W_MASK;

  always_comb begin
    pre     = '0;
    pre.P   = VAL2_MAX_W'(rm);
    pre.Cp  = carry_in;
    pre.K   = w_kind;
    // An ASR fills with the sign bit of the original operand.
    pre.F   = (w_kind == ASR) ? rm[DATA_W-1] : 1'b0;

    if (is_mem_command) begin
      pre.P = VAL2_MAX_W'(shift_operand);
      pre.K = LSL;
      pre.F = 1'b0;
    end else if (immd) begin
      // With A>0 the rotate leaves the carry equal to the new MSB. With
      // A==0 the carry stays at carry_in.
      pre.P = VAL2_MAX_W'(shift_operand[7:0]);
      pre.K = ROR;
      pre.F = 1'b0;
      pre.A = w_rot_amt;
    end else if (!reg_shift) begin
      if (w_sh != 5'd0) begin
        pre.A = VAL2_AMT_W'(w_sh);
      end else begin
        case (w_kind)
          LSL: ;                        // plain rm with carry_in
          LSR: pre.A = W_AMT;           // encoded #32
          ASR: pre.A = W_AMT;           // encoded #32
          ROR: begin                    // RRX: one step through the C flag
            pre.A   = VAL2_AMT_W'(1);
            pre.F   = carry_in;
            pre.rrx = 1'b1;
          end
        endcase
      end
    end else if (rs_amt != 8'd0) begin
      case (w_kind)
        LSL, LSR: begin
          if (rs_amt > W_AMT) begin
            pre.P  = '0;
            pre.Cp = 1'b0;
          end else begin
            pre.A = rs_amt;
          end
        end
        ASR: pre.A = (rs_amt > W_AMT) ? W_AMT : rs_amt;
        ROR: begin
          // A full rotation leaves the value unchanged. The carry becomes
          // the MSB.
          if (w_rs_mod == '0) pre.Cp = rm[DATA_W-1];
          else                pre.A  = w_rs_mod;
        end
      endcase
    end
  end

endmodule

// File: rtl/val2_shift_engine.sv
// -----------------------------------------------------------------------------
// val2_shift_engine
// Sequential operand-2 generator. When a request is accepted, the decoded
// preload goes into a work register. That register is then shifted by up to
// STEP bit positions per cycle until the amount is used up. The result is held
// in DONE until the consumer takes it. If out_ready and a new request arrive in
// the same cycle, the next operation loads with no bubble.
// Ports:
//   clk, rst (async, active high), flush (synchronous abort)
//   in_valid / in_ready       request handshake
//   rm, rs_amt, shift_operand, immd, reg_shift, is_mem_command, carry_in
//                             request payload, sampled only on accept
//   out_valid / out_ready     result handshake
//   val2_out, carry_out       result and shifter carry
// -----------------------------------------------------------------------------
module val2_shift_engine
  import val2_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int STEP   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rm,
  input  logic [7:0]        rs_amt,
  input  logic [11:0]       shift_operand,
  input  logic              immd,
  input  logic              reg_shift,
  input  logic              is_mem_command,
  input  logic              carry_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] val2_out,
  output logic              carry_out
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] ONES = '1;

  state_t            r_state;
  logic [DATA_W-1:0] r_work;
  logic              r_carry;
  logic [CW-1:0]     r_rem;
  shift_kind_t       r_kind;
  logic              r_fill;
  logic              r_rrx;
  logic              r_out_valid;

  preload_t          w_pre;
  logic              w_accept;
  logic [CW-1:0]     w_step;
  logic [CW-1:0]     w_lsh;
  logic [DATA_W-1:0] w_fill_mask;
  logic [DATA_W-1:0] w_lsl_out;
  logic [DATA_W-1:0] w_rsh_out;
  logic [DATA_W-1:0] w_next;
  logic              w_next_c;

  val2_decode #(.DATA_W(DATA_W)) u_decode (
    .rm             (rm),
    .rs_amt         (rs_amt),
    .shift_operand  (shift_operand),
    .immd           (immd),
    .reg_shift      (reg_shift),
    .is_mem_command (is_mem_command),
    .carry_in       (carry_in),
    .pre            (w_pre)
  );

  generate
    if (DATA_W < VAL2_MAX_W) begin : g_unused
      logic w_unused_p;
      assign w_unused_p = ^w_pre.P[VAL2_MAX_W-1:DATA_W];
    end
  endgenerate

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready && !flush;
  assign out_valid = r_out_valid;
  assign val2_out  = r_work;
  assign carry_out = r_carry;

  // This step's shift distance and its complement for the wrap-around part.
  assign w_step = (r_rem > CW'(STEP)) ? CW'(STEP) : r_rem;
  assign w_lsh  = CW'(DATA_W) - w_step;

  // Left shifts output bit DATA_W-s as the carry. Right shifts and rotates
  // output bit s-1. Taking bit 0 of the shifted words avoids wide
  // variable indices.
  assign w_lsl_out   = r_work >> w_lsh;
  assign w_rsh_out   = r_work >> (w_step - CW'(1));
  assign w_fill_mask = ~(ONES >> w_step);

  always_comb begin
    w_next   = r_work;
    w_next_c = r_carry;
    if (r_rrx) begin
      w_next   = {r_fill, r_work[DATA_W-1:1]};
      w_next_c = r_work[0];
    end else begin
      case (r_kind)
        LSL: begin
          w_next   = r_work << w_step;
          w_next_c = w_lsl_out[0];
        end
        LSR, ASR: begin
          w_next   = (r_work >> w_step) | (r_fill ? w_fill_mask : '0);
          w_next_c = w_rsh_out[0];
        end
        ROR: begin
          w_next   = (r_work >> w_step) | (r_work << w_lsh);
          w_next_c = w_rsh_out[0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_carry     <= 1'b0;
      r_rem       <= '0;
      r_kind      <= LSL;
      r_fill      <= 1'b0;
      r_rrx       <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_work  <= w_pre.P[DATA_W-1:0];
            r_carry <= w_pre.Cp;
            r_rem   <= CW'(w_pre.A);
            r_kind  <= w_pre.K;
            r_fill  <= w_pre.F;
            r_rrx   <= w_pre.rrx;
            if (w_pre.A == '0) begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= SHIFT;
              r_out_valid <= 1'b0;
            end
          end else if ((r_state == DONE) && out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        SHIFT: begin
          r_work  <= w_next;
          r_carry <= w_next_c;
          r_rem   <= r_rem - w_step;
          if (r_rem == w_step) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_val2_shift_engine.sv
module tb_val2_shift_engine;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rm;
  logic [7:0]  rs_amt;
  logic [11:0] shift_operand;
  logic        immd;
  logic        reg_shift;
  logic        is_mem_command;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] val2_out;
  logic        carry_out;

  int n_cmp  = 0;
  int n_fail = 0;

  val2_shift_engine #(.DATA_W(32), .STEP(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .rm             (rm),
    .rs_amt         (rs_amt),
    .shift_operand  (shift_operand),
    .immd           (immd),
    .reg_shift      (reg_shift),
    .is_mem_command (is_mem_command),
    .carry_in       (carry_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .val2_out       (val2_out),
    .carry_out      (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p_rm, input logic [7:0] p_rs,
                       input logic [11:0] p_so, input logic p_immd,
                       input logic p_reg, input logic p_mem, input logic p_cin);
    rm = p_rm; rs_amt = p_rs; shift_operand = p_so; immd = p_immd;
    reg_shift = p_reg; is_mem_command = p_mem; carry_in = p_cin;
  endtask

  // One request, from idle until the result is consumed. Latency counts
  // the accept cycle's edge as 1.
  task automatic run_op(input string tag, input logic [31:0] p_rm, input logic [7:0] p_rs,
                        input logic [11:0] p_so, input logic p_immd, input logic p_reg,
                        input logic p_mem, input logic p_cin,
                        input logic [31:0] e_val, input logic e_c, input int e_lat);
    int lat;
    @(negedge clk);
    drive(p_rm, p_rs, p_so, p_immd, p_reg, p_mem, p_cin);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    #1 chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Inputs changed after accept must not affect the result.
    rm = ~rm; rs_amt = ~rs_amt; carry_in = ~carry_in;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "_val2"}, val2_out, e_val);
    chk({tag, "_carry"}, 32'(carry_out), 32'(e_c));
    $display("op %s: val2=%08h carry=%0d latency=%0d", tag, val2_out, carry_out, lat);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(32'h0, 8'h0, 12'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_val2", val2_out, 32'h0);
    chk("reset_carry", 32'(carry_out), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) rst = 1'b0;

    //     tag          rm            rs     so      immd reg  mem  cin  val2          c     lat
    run_op("imm_rot",   32'h0,        8'd0,  12'h4FF, 1'b1,1'b0,1'b0,1'b0, 32'hFF000000, 1'b1, 2);
    run_op("imm_rot0",  32'h0,        8'd0,  12'h0AB, 1'b1,1'b0,1'b0,1'b1, 32'h000000AB, 1'b1, 1);
    run_op("imm_rot30", 32'h0,        8'd0,  12'hF01, 1'b1,1'b0,1'b0,1'b1, 32'h00000004, 1'b0, 5);
    run_op("lsr32",     32'h80000001, 8'd0,  12'h020, 1'b0,1'b0,1'b0,1'b0, 32'h00000000, 1'b1, 5);
    run_op("asr32",     32'h80000000, 8'd0,  12'h040, 1'b0,1'b0,1'b0,1'b0, 32'hFFFFFFFF, 1'b1, 5);
    run_op("rrx",       32'h00000003, 8'd0,  12'h060, 1'b0,1'b0,1'b0,1'b1, 32'h80000001, 1'b1, 2);
    run_op("lsl4",      32'hF000000F, 8'd0,  12'h200, 1'b0,1'b0,1'b0,1'b0, 32'h000000F0, 1'b1, 2);
    run_op("asr4",      32'h80000010, 8'd0,  12'h240, 1'b0,1'b0,1'b0,1'b1, 32'hF8000001, 1'b0, 2);
    run_op("lsl0",      32'h12345678, 8'd0,  12'h000, 1'b0,1'b0,1'b0,1'b1, 32'h12345678, 1'b1, 1);
    run_op("reg_lsl33", 32'hFFFFFFFF, 8'd33, 12'h000, 1'b0,1'b1,1'b0,1'b1, 32'h00000000, 1'b0, 1);
    run_op("reg_lsl32", 32'h00000001, 8'd32, 12'h000, 1'b0,1'b1,1'b0,1'b0, 32'h00000000, 1'b1, 5);
    run_op("reg_ror32", 32'h80000000, 8'd32, 12'h060, 1'b0,1'b1,1'b0,1'b0, 32'h80000000, 1'b1, 1);
    run_op("reg_lsr9",  32'h00000300, 8'd9,  12'h020, 1'b0,1'b1,1'b0,1'b0, 32'h00000001, 1'b1, 3);
    run_op("reg_asr40", 32'h80000000, 8'd40, 12'h040, 1'b0,1'b1,1'b0,1'b0, 32'hFFFFFFFF, 1'b1, 5);
    run_op("reg_ror36", 32'h0000000F, 8'd36, 12'h060, 1'b0,1'b1,1'b0,1'b0, 32'hF0000000, 1'b1, 2);
    run_op("reg_zero",  32'hDEADBEEF, 8'd0,  12'h020, 1'b0,1'b1,1'b0,1'b1, 32'hDEADBEEF, 1'b1, 1);
    run_op("mem_off",   32'h11111111, 8'd5,  12'hABC, 1'b1,1'b1,1'b1,1'b0, 32'h00000ABC, 1'b0, 1);

    // Handshake: result held while out_ready is low, then back-to-back load.
    @(negedge clk);
    drive(32'h0, 8'd0, 12'h4FF, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("hs_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    drive(32'h0, 8'd0, 12'h123, 1'b0, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hs_hold_valid", 32'(out_valid), 32'd1);
      chk("hs_hold_val2", val2_out, 32'hFF000000);
      chk("hs_hold_carry", 32'(carry_out), 32'd1);
      chk("hs_hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    #1 chk("hs_b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("hs_b2b_valid", 32'(out_valid), 32'd1);
    chk("hs_b2b_val2", val2_out, 32'h00000123);
    chk("hs_b2b_carry", 32'(carry_out), 32'd0);
    $display("op hs_b2b: val2=%08h carry=%0d", val2_out, carry_out);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_idle", 32'(out_valid), 32'd0);

    // Flush during SHIFT.
    @(negedge clk);
    drive(32'h80000001, 8'd0, 12'h020, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("flush_busy_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1 chk("flush_no_result", 32'(out_valid), 32'd0);
    $display("op flush_shift: out_valid=%0d", out_valid);

    // An accept coinciding with flush is ignored.
    @(negedge clk);
    drive(32'h0, 8'd0, 12'h055, 1'b0, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_accept_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("flush_accept_later", 32'(out_valid), 32'd0);
    $display("op flush_accept: out_valid=%0d", out_valid);

    // Reset mid-SHIFT.
    @(negedge clk);
    drive(32'h80000001, 8'd0, 12'h040, 1'b0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_shift_valid", 32'(out_valid), 32'd0);
    chk("rst_shift_val2", val2_out, 32'h0);
    chk("rst_shift_carry", 32'(carry_out), 32'd0);
    @(negedge clk) rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("rst_shift_no_result", 32'(out_valid), 32'd0);
    $display("op rst_shift: out_valid=%0d val2=%08h", out_valid, val2_out);

    // Reset while a result is held in DONE clears it without a clock edge.
    @(negedge clk);
    drive(32'hCAFEF00D, 8'd0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_done_pre_valid", 32'(out_valid), 32'd1);
    chk("rst_done_pre_val2", val2_out, 32'hCAFEF00D);
    #2 rst = 1'b1;
    #1;
    chk("rst_done_valid", 32'(out_valid), 32'd0);
    chk("rst_done_val2", val2_out, 32'h0);
    chk("rst_done_carry", 32'(carry_out), 32'd0);
    $display("op rst_done: out_valid=%0d val2=%08h", out_valid, val2_out);
    @(negedge clk) rst = 1'b0;

    // Recovery after reset.
    run_op("post_rst",  32'h00000081, 8'd1,  12'h060, 1'b0,1'b1,1'b0,1'b0, 32'h80000040, 1'b1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
